// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg -- shared types and constants for the I2C request arbiter.
//   state_t          : arbiter FSM states (IDLE, ISSUE, WAIT, RESP, DRAIN)
//   ADDR_W / DATA_W  : I2C slave address and data byte widths
//   DEF_NREQ         : default number of requesters
//   DEF_TIMEOUT_CYC  : default WAIT watchdog limit (I2C_ARB_TIMEOUT_EN builds)
package i2c_arb_pkg;

  localparam int ADDR_W          = 7;
  localparam int DATA_W          = 8;
  localparam int DEF_NREQ        = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if -- bundle between the requesters, the arbiter and the
// shared I2C master.
//   Requester side : req, req_wr, req_wdata (NREQ*8), req_addr (NREQ*7)
//                    gnt, resp_valid (one-hot pulses), resp_rdata, resp_err, busy
//   Master side    : m_newd, m_wr, m_wdata, m_addr (command out)
//                    m_rdata, m_done, m_err (completion in)
// Modports:
//   slave  -- the arbiter's view (requests and master status in, rest out)
//   master -- the surrounding environment's view (the mirror image)
interface i2c_req_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   resp_err;
  logic                   busy;

  logic                   m_newd;
  logic                   m_wr;
  logic [DATA_W-1:0]      m_wdata;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_done;
  logic                   m_err;

  modport slave (
    input  req, req_wr, req_wdata, req_addr, m_rdata, m_done, m_err,
    output gnt, resp_valid, resp_rdata, resp_err, busy,
           m_newd, m_wr, m_wdata, m_addr
  );

  modport master (
    output req, req_wr, req_wdata, req_addr, m_rdata, m_done, m_err,
    input  gnt, resp_valid, resp_rdata, resp_err, busy,
           m_newd, m_wr, m_wdata, m_addr
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick -- combinational round-robin picker.
//   req         : NREQ request bits
//   last_winner : index of the previous winner; search starts one above it
//   winner      : one-hot winner (all zero when no request)
//   valid       : at least one request is present
module i2c_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  // One spare bit so last_winner + k never wraps before the modulo step.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable written in an always_comb gets a value before any
  // condition, so no path can leave it holding state (no latch).
  always_comb begin
    winner = '0;
    sum    = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_winner} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (winner == '0 && req[cand]) winner[cand] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter -- shares one I2C master between NREQ requesters.
// A round-robin winner is picked in IDLE and its command fields are latched;
// ISSUE pulses gnt/m_newd; WAIT holds until the master reports done or error;
// RESP pulses resp_valid back to the winner.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : i2c_req_arbiter_if.slave (requests, responses, master command)
// Parameters: NREQ (2..8), TIMEOUT_CYC (WAIT watchdog limit).
// Optional feature: define I2C_ARB_TIMEOUT_EN to add the WAIT watchdog. On
// expiry an error response (rdata 0) is returned, then DRAIN swallows the
// master's late completion before the next arbitration.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic              clk,
  input logic              rst_n,
  i2c_req_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);

  state_t            state, state_next;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  last_winner;
  logic [NREQ-1:0]   pick_oh;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_wr;
  logic [DATA_W-1:0] pick_wdata;
  logic [ADDR_W-1:0] pick_addr;
  logic              m_evt;

  logic              m_wr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic [NREQ-1:0]   gnt_c;
  logic [NREQ-1:0]   resp_valid_c;

  i2c_rr_pick #(.NREQ(NREQ)) u_pick (
    .req         (bus.req),
    .last_winner (last_winner),
    .winner      (pick_oh),
    .valid       (pick_valid)
  );

  // One-hot mux of the winner's index and command fields.
  always_comb begin
    pick_idx   = '0;
    pick_wr    = 1'b0;
    pick_wdata = '0;
    pick_addr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx   = IDX_W'(i);
        pick_wr    = bus.req_wr[i];
        pick_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        pick_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Done and error both end the transfer; error wins when both arrive.
  assign m_evt = bus.m_done | bus.m_err;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] wd_cnt;
  logic             timed_out;
  logic             wd_expire;

  // A real completion in the expiry cycle takes precedence over the watchdog.
  assign wd_expire = (state == WAIT) && !m_evt &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (pick_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (m_evt) state_next = RESP;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (wd_expire) state_next = RESP;
`endif
      end
`ifdef I2C_ARB_TIMEOUT_EN
      RESP:  state_next = timed_out ? DRAIN : IDLE;
      DRAIN: if (m_evt) state_next = IDLE;
`else
      RESP:  state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_c        = '0;
    resp_valid_c = '0;
    if (state == ISSUE) gnt_c        = NREQ'(1) << win_idx;
    if (state == RESP)  resp_valid_c = NREQ'(1) << win_idx;
  end

  assign bus.gnt        = gnt_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.m_newd     = (state == ISSUE);
  assign bus.busy       = (state != IDLE);
  assign bus.m_wr       = m_wr_q;
  assign bus.m_wdata    = m_wdata_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      win_idx      <= '0;
      last_winner  <= IDX_W'(NREQ - 1);
      m_wr_q       <= 1'b0;
      m_wdata_q    <= '0;
      m_addr_q     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt       <= '0;
      timed_out    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Command fields stay frozen from here until the next arbitration.
          if (pick_valid) begin
            win_idx   <= pick_idx;
            m_wr_q    <= pick_wr;
            m_wdata_q <= pick_wdata;
            m_addr_q  <= pick_addr;
          end
        end
        ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt    <= '0;
          timed_out <= 1'b0;
`endif
        end
        WAIT: begin
          if (m_evt) begin
            resp_rdata_q <= bus.m_rdata;
            resp_err_q   <= bus.m_err;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd_expire) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            timed_out    <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        RESP: last_winner <= win_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter -- scoreboard bench for i2c_req_arbiter.
// The driver predicts each grant and response from a round-robin model of the
// pending request set and pushes them into queues; a negedge monitor pops and
// compares whenever the DUT pulses gnt or resp_valid.
// Define I2C_ARB_TIMEOUT_EN to also exercise the watchdog/DRAIN path.
module tb_i2c_req_arbiter;
  import i2c_arb_pkg::*;

  localparam int NREQ        = 4;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n;

  i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        w;
    bit        wr;
    logic [6:0] addr;
    logic [7:0] wdata;
  } gnt_exp_t;

  typedef struct {
    int         w;
    logic [7:0] rdata;
    bit         err;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int checks = 0;
  int errors = 0;

  // Requester-side model state.
  bit         pend [NREQ];
  bit         wr_f [NREQ];
  logic [6:0] ad_f [NREQ];
  logic [7:0] wd_f [NREQ];
  int         last_model = NREQ - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [6:0] addr, input logic [7:0] wdata);
    pend[i] = 1'b1;
    wr_f[i] = wr;
    ad_f[i] = addr;
    wd_f[i] = wdata;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                = pend[i];
      bus.req_wr[i]             = wr_f[i];
      bus.req_wdata[i*8 +: 8]   = wd_f[i];
      bus.req_addr[i*7 +: 7]    = ad_f[i];
    end
  endtask

  // Round robin: first pending requester strictly after the last winner.
  function automatic int model_pick();
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last_model + k) % NREQ;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Waits for the grant of a predicted winner; returns negedges waited.
  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.gnt == '0 && lat < 20);
  endtask

  // One full transaction. Starts at a negedge; ends at the negedge where
  // resp_valid is visible. from_resp: started in the RESP cycle of the
  // previous transaction, so arbitration is one cycle later.
  task automatic round(input int delay, input bit d, input bit e, input logic [7:0] rdata,
                       input bit from_resp, input logic [NREQ-1:0] wdraw,
                       output logic [NREQ-1:0] gnt_seen);
    int w, lat;
    logic [6:0] addr_exp;
    drive_req();
    w = model_pick();
    addr_exp = ad_f[w];
    gq.push_back('{w, wr_f[w], ad_f[w], wd_f[w]});
    wait_gnt(lat);
    check("gnt_latency", lat, from_resp ? 2 : 1);
    gnt_seen = bus.gnt;
    pend[w] = 1'b0;
    for (int i = 0; i < NREQ; i++) if (wdraw[i]) pend[i] = 1'b0;
    drive_req();
    repeat (delay) @(negedge clk);
    bus.m_rdata = rdata;
    bus.m_done  = d;
    bus.m_err   = e;
    rq.push_back('{w, rdata, e});
    @(negedge clk);
    bus.m_done  = 1'b0;
    bus.m_err   = 1'b0;
    bus.m_rdata = 8'($urandom);
    check("resp_latency", bus.resp_valid, 32'(1) << w);
    check("m_addr_hold", bus.m_addr, addr_exp);
    last_model = w;
  endtask

  // Monitor: compares every gnt / resp_valid pulse against the scoreboard.
  logic [NREQ-1:0] prev_gnt = '0;
  logic [NREQ-1:0] prev_rsp = '0;
  gnt_exp_t ge;
  rsp_exp_t re;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
      prev_rsp = '0;
    end else begin
      if (prev_gnt != '0) begin
        check("gnt_width", bus.gnt, 0);
        check("m_newd_width", bus.m_newd, 0);
      end
      if (prev_rsp != '0) check("resp_width", bus.resp_valid, 0);
      if (bus.gnt != '0) begin
        if (gq.size() == 0) check("gnt_unexpected", bus.gnt, 0);
        else begin
          ge = gq.pop_front();
          check("gnt", bus.gnt, 32'(1) << ge.w);
          check("m_newd", bus.m_newd, 1);
          check("m_wr", bus.m_wr, ge.wr);
          check("m_addr", bus.m_addr, ge.addr);
          check("m_wdata", bus.m_wdata, ge.wdata);
        end
      end
      if (bus.resp_valid != '0) begin
        if (rq.size() == 0) check("resp_unexpected", bus.resp_valid, 0);
        else begin
          re = rq.pop_front();
          check("resp_valid", bus.resp_valid, 32'(1) << re.w);
          check("resp_rdata", bus.resp_rdata, re.rdata);
          check("resp_err", bus.resp_err, re.err);
        end
      end
      prev_gnt = bus.gnt;
      prev_rsp = bus.resp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_m_newd"}, bus.m_newd, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_m_wr"}, bus.m_wr, 0);
    check({tag, "_m_wdata"}, bus.m_wdata, 0);
    check({tag, "_m_addr"}, bus.m_addr, 0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 0);
    check({tag, "_resp_err"}, bus.resp_err, 0);
  endtask

  initial begin
    logic [NREQ-1:0] gs;
    int order [5];
    int lat, w;
    bit from_resp;
    logic [NREQ-1:0] wdraw;
    int sel;

    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; wr_f[i] = 1'b0; ad_f[i] = '0; wd_f[i] = '0;
    end
    drive_req();
    bus.m_rdata = '0;
    bus.m_done  = 1'b0;
    bus.m_err   = 1'b0;
    #1;
    check_all_zero("reset");

    // Fairness: all four requesting, each re-requests after its grant.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
    for (int k = 0; k < 5; k++) begin
      round($urandom_range(1, 4), 1'b1, 1'b0, 8'($urandom), k != 0, '0, gs);
      check("rr_order", gs, 32'(1) << order[k]);
      w = last_model;
      set_req(w, 1'($urandom), 7'($urandom), 8'($urandom));
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive_req();
    repeat (2) @(negedge clk);

    // Single write, completion 20 cycles after the grant.
    set_req(0, 1'b1, 7'h2A, 8'h5C);
    round(20, 1'b1, 1'b0, 8'h00, 1'b0, '0, gs);
    check("write_gnt", gs, 4'b0001);
    repeat (2) @(negedge clk);

    // Read with data, then read ending in done+err together.
    set_req(2, 1'b0, 7'h31, 8'h00);
    round(5, 1'b1, 1'b0, 8'hA7, 1'b0, '0, gs);
    check("read_rdata", bus.resp_rdata, 8'hA7);
    check("read_err", bus.resp_err, 0);
    set_req(2, 1'b0, 7'h32, 8'h00);
    round(3, 1'b1, 1'b1, 8'h3C, 1'b1, '0, gs);
    check("done_err_err", bus.resp_err, 1);
    repeat (2) @(negedge clk);

    // Randomized traffic with withdrawals and stray completions in IDLE.
    from_resp = 1'b0;
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
      if (!any_pend()) set_req($urandom_range(0, NREQ - 1), 1'($urandom), 7'($urandom), 8'($urandom));
      wdraw = '0;
      for (int i = 0; i < NREQ; i++) wdraw[i] = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      round($urandom_range(1, 8), sel != 2, sel >= 2, 8'($urandom), from_resp, wdraw, gs);
      from_resp = 1'b1;
      if (!any_pend() && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.m_done = 1'b1;
        bus.m_err  = 1'($urandom);
        @(negedge clk);
        bus.m_done = 1'b0;
        bus.m_err  = 1'b0;
        from_resp = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive_req();
    repeat (3) @(negedge clk);

    // Reset while waiting on the master: transaction discarded.
    set_req(1, 1'b1, 7'h55, 8'hAA);
    drive_req();
    w = model_pick();
    gq.push_back('{w, wr_f[w], ad_f[w], wd_f[w]});
    wait_gnt(lat);
    check("pre_reset_gnt_latency", lat, 1);
    pend[1] = 1'b0;
    drive_req();
    repeat (3) @(negedge clk);
    check("pre_reset_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    rst_n = 1'b1;
    last_model = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
    round(2, 1'b1, 1'b0, 8'($urandom), 1'b0, '0, gs);
    check("post_reset_winner", gs, 4'b0001);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive_req();
    repeat (3) @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: no completion, error response after TIMEOUT_CYC WAIT cycles.
    set_req(3, 1'b0, 7'h11, 8'h00);
    drive_req();
    w = model_pick();
    gq.push_back('{w, wr_f[w], ad_f[w], wd_f[w]});
    wait_gnt(lat);
    check("to_gnt_latency", lat, 1);
    pend[3] = 1'b0;
    drive_req();
    rq.push_back('{w, 8'h00, 1'b1});
    bus.m_rdata = 8'hFF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.resp_valid == '0 && lat < 40);
    check("to_resp_latency", lat, TIMEOUT_CYC + 1);
    last_model = w;
    repeat (5) @(negedge clk);
    check("drain_busy", bus.busy, 1);
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    check("drain_exit_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
`endif

    check("gnt_queue_empty", gq.size(), 0);
    check("resp_queue_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
